// File: rtl/sc_regbank_writer.sv
// sc_regbank_writer: write-side controller for a bank of active-low-write registers.
// Each request is written with a one-cycle strobe to one register, then read back.
// The readback is compared against the written data. Completion is reported with a
// one-cycle Done pulse. Error is set for a bad address or a readback mismatch.
module sc_regbank_writer #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REGS      = 8,
  parameter int ADDRWIDTH     = 3
) (
  input  logic                              SC_RegBANKWR_CLOCK_50,
  input  logic                              SC_RegBANKWR_Reset_InHigh,
  input  logic                              SC_RegBANKWR_Req_InHigh,
  input  logic [ADDRWIDTH-1:0]              SC_RegBANKWR_Addr_In,
  input  logic [DATAWIDTH_BUS-1:0]          SC_RegBANKWR_Data_In,
  output logic                              SC_RegBANKWR_Ready_Out,
  output logic [DATAWIDTH_BUS-1:0]          SC_RegBANKWR_DataBUS_Out,
  output logic [NUM_REGS-1:0]               SC_RegBANKWR_Write_OutLow,
  input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegBANKWR_ReadBUS_In,
  output logic                              SC_RegBANKWR_Done_OutHigh,
  output logic                              SC_RegBANKWR_Error_OutHigh
);

  localparam int ADDR_SPACE = 2**ADDRWIDTH;
  // One extra bit, so that NUM_REGS == 2**ADDRWIDTH is still representable.
  localparam logic [ADDRWIDTH:0] NUM_REGS_W = (ADDRWIDTH+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, RESP} state_t;

  typedef struct packed {
    logic [ADDRWIDTH-1:0]     addr;
    logic [DATAWIDTH_BUS-1:0] data;
  } wrReq_t;

  state_t                state;
  wrReq_t                latReq;
  logic                  addrInRange;
  logic [ADDR_SPACE-1:0] readMatch;

  assign SC_RegBANKWR_Ready_Out = (state == IDLE);
  assign addrInRange = ({1'b0, SC_RegBANKWR_Addr_In} < NUM_REGS_W);

  // Per-register readback compare. Slots past NUM_REGS are padded as
  // "no match", so the address index always covers the whole vector.
  for (genvar g = 0; g < ADDR_SPACE; g++) begin : gReadCmp
    if (g < NUM_REGS) begin : gReal
      assign readMatch[g] =
        (SC_RegBANKWR_ReadBUS_In[g*DATAWIDTH_BUS +: DATAWIDTH_BUS] == latReq.data);
    end else begin : gPad
      assign readMatch[g] = 1'b0;
    end
  end

  // Control FSM. Every output except Ready comes straight from a flop.
  always_ff @(posedge SC_RegBANKWR_CLOCK_50 or posedge SC_RegBANKWR_Reset_InHigh) begin
    if (SC_RegBANKWR_Reset_InHigh) begin
      state                      <= IDLE;
      latReq                     <= '0;
      SC_RegBANKWR_Write_OutLow  <= '1;
      SC_RegBANKWR_DataBUS_Out   <= '0;
      SC_RegBANKWR_Done_OutHigh  <= 1'b0;
      SC_RegBANKWR_Error_OutHigh <= 1'b0;
    end else begin
      SC_RegBANKWR_Done_OutHigh  <= 1'b0;
      SC_RegBANKWR_Error_OutHigh <= 1'b0;
      SC_RegBANKWR_Write_OutLow  <= '1;
      case (state)
        IDLE: begin
          if (SC_RegBANKWR_Req_InHigh) begin
            latReq.addr <= SC_RegBANKWR_Addr_In;
            latReq.data <= SC_RegBANKWR_Data_In;
            if (addrInRange) begin
              state                     <= WRITE;
              SC_RegBANKWR_Write_OutLow <= ~(NUM_REGS'(1) << SC_RegBANKWR_Addr_In);
              SC_RegBANKWR_DataBUS_Out  <= SC_RegBANKWR_Data_In;
            end else begin
              // A bad address skips the strobe entirely and reports at once.
              state                      <= RESP;
              SC_RegBANKWR_Done_OutHigh  <= 1'b1;
              SC_RegBANKWR_Error_OutHigh <= 1'b1;
            end
          end
        end
        WRITE:  state <= VERIFY;
        VERIFY: begin
          state                      <= RESP;
          SC_RegBANKWR_Done_OutHigh  <= 1'b1;
          SC_RegBANKWR_Error_OutHigh <= ~readMatch[latReq.addr];
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_regbank_writer.sv
// Directed bench for sc_regbank_writer. It uses a behavioural register bank,
// plus a second instance with NUM_REGS=6 for the bad-address cases.
module tb_sc_regbank_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  addr;
  logic [7:0]  data;
  logic        ready;
  logic [7:0]  dataBus;
  logic [7:0]  writeLow;
  logic [63:0] readBus;
  logic        done;
  logic        error;

  logic        req6;
  logic [2:0]  addr6;
  logic [7:0]  data6;
  logic        ready6;
  logic [7:0]  dataBus6;
  logic [5:0]  writeLow6;
  logic [47:0] readBus6;
  logic        done6;
  logic        error6;

  logic [7:0]  mreg [8];
  logic        stuck5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_regbank_writer #(.DATAWIDTH_BUS(8), .NUM_REGS(8), .ADDRWIDTH(3)) dut (
    .SC_RegBANKWR_CLOCK_50      (clk),
    .SC_RegBANKWR_Reset_InHigh  (rst),
    .SC_RegBANKWR_Req_InHigh    (req),
    .SC_RegBANKWR_Addr_In       (addr),
    .SC_RegBANKWR_Data_In       (data),
    .SC_RegBANKWR_Ready_Out     (ready),
    .SC_RegBANKWR_DataBUS_Out   (dataBus),
    .SC_RegBANKWR_Write_OutLow  (writeLow),
    .SC_RegBANKWR_ReadBUS_In    (readBus),
    .SC_RegBANKWR_Done_OutHigh  (done),
    .SC_RegBANKWR_Error_OutHigh (error)
  );

  sc_regbank_writer #(.DATAWIDTH_BUS(8), .NUM_REGS(6), .ADDRWIDTH(3)) dut6 (
    .SC_RegBANKWR_CLOCK_50      (clk),
    .SC_RegBANKWR_Reset_InHigh  (rst),
    .SC_RegBANKWR_Req_InHigh    (req6),
    .SC_RegBANKWR_Addr_In       (addr6),
    .SC_RegBANKWR_Data_In       (data6),
    .SC_RegBANKWR_Ready_Out     (ready6),
    .SC_RegBANKWR_DataBUS_Out   (dataBus6),
    .SC_RegBANKWR_Write_OutLow  (writeLow6),
    .SC_RegBANKWR_ReadBUS_In    (readBus6),
    .SC_RegBANKWR_Done_OutHigh  (done6),
    .SC_RegBANKWR_Error_OutHigh (error6)
  );

  assign readBus6 = '0;

  // Behavioural register bank: async reset, captures the bus while its strobe is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mreg[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (!writeLow[i]) mreg[i] <= dataBus;
    end
  end

  // Register outputs on the read bus. Slot 5 can be forced to a stuck-bit value.
  always_comb begin
    readBus = '0;
    for (int i = 0; i < 8; i++) readBus[i*8 +: 8] = mreg[i];
    if (stuck5) readBus[40 +: 8] = 8'h3D;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete write. The inputs are scrambled right after acceptance, to show
  // that only the latched copies are used.
  task automatic doWrite(input logic [2:0] a, input logic [7:0] d, input logic expErr);
    logic [7:0] strobeExp;
    strobeExp = ~(8'b1 << a);
    req = 1'b1; addr = a; data = d;
    step();
    req = 1'b0; addr = ~a; data = ~d;
    check("wr_strobe", writeLow, strobeExp);
    check("wr_bus", dataBus, d);
    check("wr_ready", ready, 0);
    step();
    check("vf_strobe", writeLow, 8'hFF);
    check("vf_done", done, 0);
    step();
    check("rs_done", done, 1);
    check("rs_err", error, expErr);
    step();
    check("idle_done", done, 0);
    check("idle_ready", ready, 1);
    check("bus_hold", dataBus, d);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; data = '0; stuck5 = 1'b0;
    req6 = 1'b0; addr6 = '0; data6 = '0;
    step(); step();
    check("rst_strobe", writeLow, 8'hFF);
    check("rst_bus", dataBus, 8'h00);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;
    step();
    check("post_rst_ready", ready, 1);

    // 1: basic write with a matching readback
    doWrite(3'd2, 8'hA5, 1'b0);
    check("t1_reg2", mreg[2], 8'hA5);

    // 2: stuck bit on the reg5 readback
    stuck5 = 1'b1;
    doWrite(3'd5, 8'h3C, 1'b1);
    stuck5 = 1'b0;

    // 3: bad addresses on the 6-register instance (7, then the boundary 6)
    req6 = 1'b1; addr6 = 3'd7; data6 = 8'hFF;
    step();
    req6 = 1'b0;
    check("t3_strobe", writeLow6, 6'h3F);
    check("t3_done", done6, 1);
    check("t3_err", error6, 1);
    check("t3_ready", ready6, 0);
    step();
    check("t3_done_once", done6, 0);
    check("t3_ready_back", ready6, 1);
    check("t3_bus", dataBus6, 8'h00);
    req6 = 1'b1; addr6 = 3'd6; data6 = 8'h12;
    step();
    req6 = 1'b0;
    check("t3b_strobe", writeLow6, 6'h3F);
    check("t3b_done", done6, 1);
    check("t3b_err", error6, 1);
    step();

    // 4: Req held high with the inputs changing every cycle
    req = 1'b1; addr = 3'd0; data = 8'h11;
    step();
    check("t4_strobe0", writeLow, 8'hFE);
    check("t4_bus0", dataBus, 8'h11);
    check("t4_ready_a", ready, 0);
    addr = 3'd3; data = 8'h22;
    step();
    check("t4_ready_b", ready, 0);
    check("t4_strobe_off", writeLow, 8'hFF);
    addr = 3'd4; data = 8'h33;
    step();
    check("t4_ready_c", ready, 0);
    check("t4_done0", done, 1);
    check("t4_err0", error, 0);
    addr = 3'd7; data = 8'h77;
    step();
    check("t4_ready_idle", ready, 1);
    check("t4_nodone", done, 0);
    step();
    check("t4_strobe7", writeLow, 8'h7F);
    check("t4_bus7", dataBus, 8'h77);
    req = 1'b0; addr = 3'd1; data = 8'h99;
    step(); step();
    check("t4_done7", done, 1);
    check("t4_err7", error, 0);
    step();
    check("t4_reg0", mreg[0], 8'h11);
    check("t4_reg7", mreg[7], 8'h77);
    check("t4_reg3", mreg[3], 8'h00);
    check("t4_reg4", mreg[4], 8'h00);
    check("t4_reg1", mreg[1], 8'h00);

    // 5: reset while the strobe is low
    req = 1'b1; addr = 3'd6; data = 8'h5A;
    step();
    req = 1'b0;
    check("t5_strobe", writeLow, 8'hBF);
    #2 rst = 1'b1;
    #1;
    check("t5_async_strobe", writeLow, 8'hFF);
    check("t5_async_bus", dataBus, 8'h00);
    check("t5_async_ready", ready, 1);
    step();
    check("t5_rst_nodone", done, 0);
    rst = 1'b0;
    step();
    check("t5_nodone_a", done, 0);
    check("t5_ready", ready, 1);
    step();
    check("t5_nodone_b", done, 0);
    doWrite(3'd6, 8'h5A, 1'b0);
    check("t5_reg6", mreg[6], 8'h5A);

    // 6: all-zeros and all-ones to every register in turn
    for (int r = 0; r < 8; r++) begin
      doWrite(3'(r), 8'h00, 1'b0);
      check("t6_reg00", mreg[r], 8'h00);
      doWrite(3'(r), 8'hFF, 1'b0);
      check("t6_regFF", mreg[r], 8'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
